fanout_pipe_tree: RTL



---
 rtl/fanout_pipe_tree.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fanout_pipe_tree.sv
// fanout_pipe_tree: registered broadcast tree from one WIDTH-bit source to
// NUM_OUT channels over LEVELS stages, each driver feeding at most FANOUT loads.
// Optional macro FANOUT_OUT_HOLD_EN: a disabled leaf holds its value instead of
// being forced low.
module fanout_pipe_tree #(
    parameter int unsigned         WIDTH    = 1,
    parameter int unsigned         NUM_OUT  = 20,
    parameter int unsigned         FANOUT   = 5,
    parameter logic [NUM_OUT-1:0]  INV_MASK = {NUM_OUT{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [NUM_OUT-1:0]         out_en,
    output logic                       out_valid,
    output logic [NUM_OUT*WIDTH-1:0]   out_data
);

    // Integer power used to size the tree at elaboration time.
    function automatic int unsigned ipow(input int unsigned b, input int unsigned e);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    // Smallest L >= 1 with FANOUT^L >= NUM_OUT.
    function automatic int unsigned calc_levels(input int unsigned n, input int unsigned f);
        int unsigned l;
        int unsigned p;
        l = 1;
        p = f;
        while (p < n) begin
            p = p * f;
            l = l + 1;
        end
        return l;
    endfunction

    localparam int unsigned LEVELS = calc_levels(NUM_OUT, FANOUT);

    // Node count of zero-based level li: ceil(NUM_OUT / FANOUT^(LEVELS-1-li)).
    function automatic int unsigned lvl_size(input int unsigned li);
        int unsigned d;
        d = ipow(FANOUT, LEVELS - 1 - li);
        return (NUM_OUT + d - 1) / d;
    endfunction

    // Position of the first node of zero-based level li in the flat node array.
    function automatic int unsigned lvl_off(input int unsigned li);
        int unsigned s;
        s = 0;
        for (int unsigned m = 0; m < li; m++) s = s + lvl_size(m);
        return s;
    endfunction

    localparam int unsigned TOTAL    = lvl_off(LEVELS);
    localparam int unsigned LEAF_OFF = lvl_off(LEVELS - 1);

    logic [WIDTH-1:0]  node_q [TOTAL];
    logic [LEVELS-1:0] vld_q;

    for (genvar li = 0; li < int'(LEVELS); li++) begin : g_lvl
        localparam int unsigned N   = lvl_size(li);
        localparam int unsigned OFF = lvl_off(li);

        for (genvar j = 0; j < int'(N); j++) begin : g_node
            logic [WIDTH-1:0] src_c;

            if (li == 0) begin : g_root
                assign src_c = in_data;
            end else begin : g_child
                localparam int unsigned PIDX = lvl_off(li - 1) + (j / FANOUT);
                assign src_c = node_q[PIDX];
            end

            if (li == int'(LEVELS) - 1) begin : g_leaf
                // Leaf register: polarity and per-channel enable applied here.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        node_q[OFF + j] <= '0;
`ifdef FANOUT_OUT_HOLD_EN
                    end else if (ce && out_en[j]) begin
                        node_q[OFF + j] <= src_c ^ {WIDTH{INV_MASK[j]}};
                    end
`else
                    end else if (ce) begin
                        node_q[OFF + j] <= out_en[j] ? (src_c ^ {WIDTH{INV_MASK[j]}})
                                                     : '0;
                    end
`endif
                end
            end else begin : g_inner
                // Internal distribution register: reloads on every advancing edge.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        node_q[OFF + j] <= '0;
                    end else if (ce) begin
                        node_q[OFF + j] <= src_c;
                    end
                end
            end
        end
    end

    // Valid tag pipeline, matched in depth to the data tree.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (ce) begin
            vld_q[0] <= in_valid;
            for (int unsigned i = 1; i < LEVELS; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    assign out_valid = vld_q[LEVELS-1];

    for (genvar i = 0; i < int'(NUM_OUT); i++) begin : g_out
        assign out_data[i*WIDTH +: WIDTH] = node_q[LEAF_OFF + i];
    end

endmodule
